multicycle_ctrl_hs: RTL and testbench

MULTICYCLE_CTRL_HS -- requirements
Module: multicycle_ctrl_hs

---
 rtl/multicycle_ctrl_hs_if.sv | 34 +++
 rtl/multicycle_ctrl_hs.sv | 130 +++++++++++++
 tb/tb_multicycle_ctrl_hs.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_hs_if.sv
// multicycle_ctrl_hs_if: datapath-facing bundle between the multicycle controller and its datapath
interface multicycle_ctrl_hs_if #(parameter int CNT_W = 32);
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic Zero;
  logic mem_ready;
  logic PCWrite;
  logic PCWriteCond;
  logic [1:0] IorD;
  logic MemRead;
  logic MemWrite;
  logic IRWrite;
  logic [2:0] MemtoReg;
  logic [1:0] RegDst;
  logic RegWrite;
  logic ExtOp;
  logic LuiOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUOp;
  logic [1:0] PCSource;
  logic fault;
  logic [CNT_W-1:0] retired;
  modport master (
    input OpCode, Funct, Zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
    RegWrite, ExtOp, LuiOp, ALUSrcA, ALUSrcB, ALUOp, PCSource, fault, retired
  );
  modport slave (
    output OpCode, Funct, Zero, mem_ready,
    input PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
    RegWrite, ExtOp, LuiOp, ALUSrcA, ALUSrcB, ALUOp, PCSource, fault, retired
  );
endinterface

// File: rtl/multicycle_ctrl_hs.sv
// multicycle_ctrl_hs: multicycle MIPS-style control FSM with memory-wait timeout and retired-instruction counter
module multicycle_ctrl_hs #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  multicycle_ctrl_hs_if.master bus
);
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_FAULT} state_t;
  state_t st, nxt;
  logic [7:0] wait_cnt;
  logic [CNT_W-1:0] retired_q;
  logic ret, timeout, rtype, is_j, is_jal, is_beq, is_lw, is_sw, imm_op, valid_op;
  logic is_jr, is_jalr, shamt_fn;
  assign rtype = bus.OpCode == 6'h00;
  assign is_j = bus.OpCode == 6'h02;
  assign is_jal = bus.OpCode == 6'h03;
  assign is_beq = bus.OpCode == 6'h04;
  assign is_lw = bus.OpCode == 6'h23;
  assign is_sw = bus.OpCode == 6'h2b;
  assign imm_op = bus.OpCode inside {6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f};
  assign valid_op = rtype | is_j | is_jal | is_beq | is_lw | is_sw | imm_op;
  assign is_jr = bus.Funct == 6'h08;
  assign is_jalr = bus.Funct == 6'h09;
  assign shamt_fn = bus.Funct inside {6'h00, 6'h02, 6'h03};
  // a wait cycle that would bring the counter up to TIMEOUT aborts the access
  assign timeout = !bus.mem_ready && wait_cnt == 8'(TIMEOUT - 1);
  assign bus.fault = st == S_FAULT;
  assign bus.retired = retired_q;
  always_comb begin
    bus.PCWrite = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD = 2'b00;
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite = 1'b0;
    bus.MemtoReg = 3'b000;
    bus.RegDst = 2'b00;
    bus.RegWrite = 1'b0;
    bus.ExtOp = 1'b0;
    bus.LuiOp = 1'b0;
    bus.ALUSrcA = 2'b00;
    bus.ALUSrcB = 2'b00;
    bus.ALUOp = 4'd0;
    bus.PCSource = 2'b00;
    ret = 1'b0;
    nxt = st;
    case (st)
      S_IF: begin
        bus.MemRead = 1'b1;
        if (bus.mem_ready) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          bus.ALUSrcB = 2'b01;
          nxt = S_ID;
        end else if (timeout) nxt = S_FAULT;
      end
      S_ID: begin
        bus.ALUSrcB = 2'b11;
        bus.ExtOp = 1'b1;
        if (is_j || is_jal) begin
          bus.PCSource = 2'b10;
          bus.PCWrite = 1'b1;
          bus.RegDst = is_jal ? 2'b10 : 2'b00;
          bus.MemtoReg = is_jal ? 3'b010 : 3'b000;
          bus.RegWrite = is_jal;
          ret = 1'b1;
          nxt = S_IF;
        end else nxt = valid_op ? S_EX : S_FAULT;
      end
      S_EX: begin
        bus.ALUSrcA = 2'b01;
        if (rtype && (is_jr || is_jalr)) begin
          bus.ALUOp = 4'd6;
          bus.PCWrite = 1'b1;
          bus.RegDst = is_jalr ? 2'b01 : 2'b00;
          bus.MemtoReg = is_jalr ? 3'b010 : 3'b000;
          bus.RegWrite = is_jalr;
          ret = 1'b1;
          nxt = S_IF;
        end else if (rtype) begin
          bus.ALUSrcA = shamt_fn ? 2'b10 : 2'b01;
          bus.ALUOp = 4'd2;
          nxt = S_WB;
        end else if (is_beq) begin
          bus.ALUOp = 4'd1;
          bus.PCWriteCond = 1'b1;
          bus.PCSource = 2'b01;
          ret = 1'b1;
          nxt = S_IF;
        end else begin
          bus.ALUSrcB = 2'b10;
          bus.ExtOp = !(bus.OpCode inside {6'h0c, 6'h0f});
          bus.LuiOp = bus.OpCode == 6'h0f;
          bus.ALUOp = bus.OpCode == 6'h0c ? 4'd3 : bus.OpCode == 6'h0a ? 4'd4 : bus.OpCode == 6'h0b ? 4'd5 : 4'd0;
          nxt = (is_lw || is_sw) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        bus.IorD = 2'b01;
        bus.MemRead = is_lw;
        bus.MemWrite = is_sw;
        if (bus.mem_ready) begin
          ret = is_sw;
          nxt = is_lw ? S_WB : S_IF;
        end else if (timeout) nxt = S_FAULT;
      end
      S_WB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst = rtype ? 2'b01 : 2'b00;
        bus.MemtoReg = is_lw ? 3'b000 : 3'b001;
        ret = 1'b1;
        nxt = S_IF;
      end
      default: nxt = S_FAULT;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= S_IF;
      wait_cnt <= 8'd0;
      retired_q <= '0;
    end else begin
      st <= nxt;
      wait_cnt <= ((st == S_IF || st == S_MEM) && !bus.mem_ready && nxt == st) ? wait_cnt + 8'd1 : 8'd0;
      retired_q <= retired_q + CNT_W'(ret);
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// tb_multicycle_ctrl_hs: directed instruction sequences with a queued scoreboard checked each cycle
module tb_multicycle_ctrl_hs;
  typedef struct packed {
    logic PCWrite;
    logic PCWriteCond;
    logic [1:0] IorD;
    logic MemRead;
    logic MemWrite;
    logic IRWrite;
    logic [2:0] MemtoReg;
    logic [1:0] RegDst;
    logic RegWrite;
    logic ExtOp;
    logic LuiOp;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUOp;
    logic [1:0] PCSource;
    logic fault;
  } ctl_t;
  typedef struct {
    string name;
    ctl_t e;
    logic [31:0] r;
  } item_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  ctl_t act;
  item_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  multicycle_ctrl_hs_if #(.CNT_W(32)) ifc ();
  multicycle_ctrl_hs #(.TIMEOUT(4), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(ifc.master));
  always #5 clk = ~clk;
  assign act = {ifc.PCWrite, ifc.PCWriteCond, ifc.IorD, ifc.MemRead, ifc.MemWrite, ifc.IRWrite,
                ifc.MemtoReg, ifc.RegDst, ifc.RegWrite, ifc.ExtOp, ifc.LuiOp, ifc.ALUSrcA,
                ifc.ALUSrcB, ifc.ALUOp, ifc.PCSource, ifc.fault};
  function automatic ctl_t f_if(input logic rdy);
    ctl_t e = '0;
    e.MemRead = 1'b1;
    e.IRWrite = rdy;
    e.PCWrite = rdy;
    e.ALUSrcB = rdy ? 2'b01 : 2'b00;
    return e;
  endfunction
  function automatic ctl_t f_id();
    ctl_t e = '0;
    e.ALUSrcB = 2'b11;
    e.ExtOp = 1'b1;
    return e;
  endfunction
  function automatic ctl_t f_fault();
    ctl_t e = '0;
    e.fault = 1'b1;
    return e;
  endfunction
  task automatic step(input string n, input logic rs, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic rdy, input ctl_t e, input int r);
    item_t it;
    reset = rs;
    ifc.OpCode = op;
    ifc.Funct = fn;
    ifc.Zero = z;
    ifc.mem_ready = rdy;
    it.name = n;
    it.e = e;
    it.r = 32'(r);
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it = q.pop_front();
        n_cmp += 2;
        if (act !== it.e) begin
          n_bad++;
          $display("FAIL %s ctl: got %h want %h", it.name, act, it.e);
        end
        if (ifc.retired !== it.r) begin
          n_bad++;
          $display("FAIL %s retired: got %0d want %0d", it.name, ifc.retired, it.r);
        end
      end
    end
  end
  initial begin
    ctl_t e, ex_ls, ex_beq, mem_e;
    ifc.OpCode = 6'h00;
    ifc.Funct = 6'h00;
    ifc.Zero = 1'b0;
    ifc.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    ex_ls = '0; ex_ls.ALUSrcA = 2'b01; ex_ls.ALUSrcB = 2'b10; ex_ls.ExtOp = 1'b1;
    ex_beq = '0; ex_beq.ALUSrcA = 2'b01; ex_beq.ALUOp = 4'd1; ex_beq.PCWriteCond = 1'b1; ex_beq.PCSource = 2'b01;
    step("rst0", 0, 6'h00, 6'h00, 0, 0, f_if(0), 0);
    step("rst1", 0, 6'h00, 6'h00, 0, 0, f_if(0), 0);
    step("addi_if", 1, 6'h08, 6'h00, 0, 1, f_if(1), 0);
    step("addi_id", 1, 6'h08, 6'h00, 0, 1, f_id(), 0);
    step("addi_ex", 1, 6'h08, 6'h00, 0, 1, ex_ls, 0);
    e = '0; e.RegWrite = 1'b1; e.MemtoReg = 3'b001;
    step("addi_wb", 1, 6'h08, 6'h00, 0, 1, e, 0);
    step("lw_if", 1, 6'h23, 6'h00, 0, 1, f_if(1), 1);
    step("lw_id", 1, 6'h23, 6'h00, 0, 1, f_id(), 1);
    step("lw_ex", 1, 6'h23, 6'h00, 0, 1, ex_ls, 1);
    mem_e = '0; mem_e.IorD = 2'b01; mem_e.MemRead = 1'b1;
    for (int i = 0; i < 3; i++) step("lw_mem_wait", 1, 6'h23, 6'h00, 0, 0, mem_e, 1);
    step("lw_mem_done", 1, 6'h23, 6'h00, 0, 1, mem_e, 1);
    e = '0; e.RegWrite = 1'b1;
    step("lw_wb", 1, 6'h23, 6'h00, 0, 1, e, 1);
    step("beq1_if", 1, 6'h04, 6'h00, 1, 1, f_if(1), 2);
    step("beq1_id", 1, 6'h04, 6'h00, 1, 1, f_id(), 2);
    step("beq1_ex", 1, 6'h04, 6'h00, 1, 1, ex_beq, 2);
    step("beq0_if", 1, 6'h04, 6'h00, 0, 1, f_if(1), 3);
    step("beq0_id", 1, 6'h04, 6'h00, 0, 1, f_id(), 3);
    step("beq0_ex", 1, 6'h04, 6'h00, 0, 1, ex_beq, 3);
    step("sw_if", 1, 6'h2b, 6'h00, 0, 1, f_if(1), 4);
    step("sw_id", 1, 6'h2b, 6'h00, 0, 1, f_id(), 4);
    step("sw_ex", 1, 6'h2b, 6'h00, 0, 1, ex_ls, 4);
    e = '0; e.IorD = 2'b01; e.MemWrite = 1'b1;
    step("sw_mem", 1, 6'h2b, 6'h00, 0, 1, e, 4);
    step("sll_if", 1, 6'h00, 6'h00, 0, 1, f_if(1), 5);
    step("sll_id", 1, 6'h00, 6'h00, 0, 1, f_id(), 5);
    e = '0; e.ALUSrcA = 2'b10; e.ALUOp = 4'd2;
    step("sll_ex", 1, 6'h00, 6'h00, 0, 1, e, 5);
    e = '0; e.RegWrite = 1'b1; e.RegDst = 2'b01; e.MemtoReg = 3'b001;
    step("sll_wb", 1, 6'h00, 6'h00, 0, 1, e, 5);
    step("jalr_if", 1, 6'h00, 6'h09, 0, 1, f_if(1), 6);
    step("jalr_id", 1, 6'h00, 6'h09, 0, 1, f_id(), 6);
    e = '0; e.ALUSrcA = 2'b01; e.ALUOp = 4'd6; e.PCWrite = 1'b1; e.RegDst = 2'b01; e.MemtoReg = 3'b010; e.RegWrite = 1'b1;
    step("jalr_ex", 1, 6'h00, 6'h09, 0, 1, e, 6);
    step("andi_if", 1, 6'h0c, 6'h00, 0, 1, f_if(1), 7);
    step("andi_id", 1, 6'h0c, 6'h00, 0, 1, f_id(), 7);
    e = '0; e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b10; e.ALUOp = 4'd3;
    step("andi_ex", 1, 6'h0c, 6'h00, 0, 1, e, 7);
    e = '0; e.RegWrite = 1'b1; e.MemtoReg = 3'b001;
    step("andi_wb", 1, 6'h0c, 6'h00, 0, 1, e, 7);
    step("lui_if", 1, 6'h0f, 6'h00, 0, 1, f_if(1), 8);
    step("lui_id", 1, 6'h0f, 6'h00, 0, 1, f_id(), 8);
    e = '0; e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b10; e.LuiOp = 1'b1;
    step("lui_ex", 1, 6'h0f, 6'h00, 0, 1, e, 8);
    e = '0; e.RegWrite = 1'b1; e.MemtoReg = 3'b001;
    step("lui_wb", 1, 6'h0f, 6'h00, 0, 1, e, 8);
    for (int i = 0; i < 4; i++) step("to_wait", 1, 6'h08, 6'h00, 0, 0, f_if(0), 9);
    step("to_fault0", 1, 6'h08, 6'h00, 0, 1, f_fault(), 9);
    step("to_fault1", 1, 6'h08, 6'h00, 0, 1, f_fault(), 9);
    step("to_rst", 0, 6'h08, 6'h00, 0, 0, f_if(0), 0);
    step("bad_if", 1, 6'h3f, 6'h00, 0, 1, f_if(1), 0);
    step("bad_id", 1, 6'h3f, 6'h00, 0, 1, f_id(), 0);
    step("bad_fault", 1, 6'h3f, 6'h00, 0, 1, f_fault(), 0);
    step("bad_rst", 0, 6'h03, 6'h00, 0, 0, f_if(0), 0);
    step("jal_if", 1, 6'h03, 6'h00, 0, 1, f_if(1), 0);
    e = f_id(); e.PCSource = 2'b10; e.PCWrite = 1'b1; e.RegDst = 2'b10; e.MemtoReg = 3'b010; e.RegWrite = 1'b1;
    step("jal_id", 1, 6'h03, 6'h00, 0, 1, e, 0);
    step("jal_next", 1, 6'h03, 6'h00, 0, 0, f_if(0), 1);
    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
